// File: rtl/lsu_subword.sv
// -----------------------------------------------------------------------------
// lsu_subword
//
// Load/store unit placed in front of a word-only data memory that reads
// combinationally and writes on the rising clock edge.
//
// Loads pick the addressed byte or halfword lane and sign- or zero-extend it.
// Word stores are written straight through. Byte and halfword stores are done
// as a two-cycle read-modify-write:
//   1. read the word,
//   2. merge the new lane into it,
//   3. write the whole word back.
// Requests that are misaligned, or that use the reserved size, are rejected
// with a one-cycle err pulse.
//
// Parameters:
//   MISALIGN_TRAP  1: a misaligned request raises err and touches no memory.
//                  0: the low address bits are forced to alignment and the
//                     access proceeds.
//
// Ports:
//   clk        in   system clock; all state changes on the rising edge
//   reset      in   synchronous, active-low reset
//   req        in   access request, sampled only while ready=1
//   we         in   1 = store, 0 = load
//   size       in   2'b00 byte, 2'b01 half, 2'b10 word, 2'b11 reserved
//   uns        in   load extension: 1 = zero-extend, 0 = sign-extend
//   addr       in   byte address
//   wdata      in   store data, right-justified
//   ready      out  unit idle and able to accept req
//   done       out  one-cycle pulse when an access completes
//   err        out  one-cycle pulse when a request is rejected
//   rdata      out  extended load result; changed only by loads
//   mem_rd     out  data memory read enable
//   mem_wr     out  data memory write enable
//   mem_addr   out  word-aligned memory address
//   mem_wdata  out  word to write
//   mem_rdata  in   memory read word (combinational from mem_addr)
// -----------------------------------------------------------------------------
module lsu_subword #(
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD   = 2'b01,
    RMW_RD = 2'b10,
    WRITE  = 2'b11
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] addr_r;
  logic [1:0]  size_r;
  logic        we_r;
  logic        uns_r;
  logic [31:0] wdata_r;
  logic [31:0] merge_r;
  logic [31:0] rdata_r;
  logic        done_r;
  logic        err_r;
  logic        bad_req_s;

  // True when the low address bits do not suit the access size.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    logic res;
    case (sz)
      2'b00:   res = 1'b0;
      2'b01:   res = lo[0];
      2'b10:   res = (lo != 2'b00);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  // Clears the address bits below the access size.
  // This is a no-op for aligned addresses. With MISALIGN_TRAP=0 it is what
  // realigns a misaligned request before the access proceeds.
  function automatic logic [31:0] align_addr(input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] res;
    case (sz)
      2'b01:   res = {a[31:1], 1'b0};
      2'b10:   res = {a[31:2], 2'b00};
      default: res = a;
    endcase
    return res;
  endfunction

  // Selects the addressed little-endian lane and extends it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] lo, input logic un);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lo)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'h00;
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   res = un ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   res = un ? {16'h0000, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replaces the target lane of the memory word with the low bits of the store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wd,
                                             input logic [1:0] sz, input logic [1:0] lo);
    logic [31:0] res;
    res = word;
    case (sz)
      2'b00: begin
        case (lo)
          2'b00:   res[7:0]   = wd[7:0];
          2'b01:   res[15:8]  = wd[7:0];
          2'b10:   res[23:16] = wd[7:0];
          2'b11:   res[31:24] = wd[7:0];
          default: res = word;
        endcase
      end
      2'b01: begin
        if (lo[1]) res[31:16] = wd[15:0];
        else       res[15:0]  = wd[15:0];
      end
      default: res = wd;
    endcase
    return res;
  endfunction

  // Decides whether the incoming request must be rejected.
  // The reserved size is always rejected. Misalignment is rejected only in
  // trap mode.
  always_comb begin
    bad_req_s = 1'b0;
    if (size == 2'b11) begin
      bad_req_s = 1'b1;
    end else if (MISALIGN_TRAP == 1'b1) begin
      bad_req_s = is_misaligned(size, addr[1:0]);
    end else begin
      bad_req_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!req) begin
          state_nxt_s = IDLE;
        end else if (bad_req_s) begin
          state_nxt_s = IDLE;
        end else if (!we) begin
          state_nxt_s = LOAD;
        end else if (size == 2'b10) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = RMW_RD;
        end
      end
      LOAD:    state_nxt_s = IDLE;
      RMW_RD:  state_nxt_s = WRITE;
      WRITE:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Memory-side decodes.
  // Read and write enables come only from the state, so they are mutually
  // exclusive and both low while idle.
  always_comb begin
    ready     = (state_r == IDLE);
    mem_rd    = (state_r == LOAD) || (state_r == RMW_RD);
    mem_wr    = (state_r == WRITE);
    mem_addr  = {addr_r[31:2], 2'b00};
    mem_wdata = 32'h00000000;
    if (size_r == 2'b10) begin
      mem_wdata = wdata_r;
    end else begin
      mem_wdata = merge_r;
    end
  end

  // State register, request latches, merge/result registers and response pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      addr_r  <= 32'h00000000;
      size_r  <= 2'b00;
      we_r    <= 1'b0;
      uns_r   <= 1'b0;
      wdata_r <= 32'h00000000;
      merge_r <= 32'h00000000;
      rdata_r <= 32'h00000000;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req) begin
            addr_r  <= align_addr(addr, size);
            size_r  <= size;
            we_r    <= we;
            uns_r   <= uns;
            wdata_r <= wdata;
            err_r   <= bad_req_s;
          end
        end
        LOAD: begin
          rdata_r <= load_extract(mem_rdata, size_r, addr_r[1:0], uns_r);
          done_r  <= 1'b1;
        end
        RMW_RD: begin
          merge_r <= merge_lane(mem_rdata, wdata_r, size_r, addr_r[1:0]);
        end
        WRITE: begin
          done_r <= 1'b1;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign done  = done_r;
  assign err   = err_r;
  assign rdata = rdata_r;

endmodule

// File: tb/tb_lsu_subword.sv
// -----------------------------------------------------------------------------
// tb_lsu_subword
//
// Directed bench for lsu_subword. Two instances run side by side:
//   dut1  MISALIGN_TRAP=1
//   dut0  MISALIGN_TRAP=0
// Each instance has its own small word memory.
//
// Protocol used by the bench:
//   - Inputs are driven 1 time unit after a rising edge.
//   - Outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_lsu_subword;

  logic        clk;
  logic        reset;
  logic        req1;
  logic        req0;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        ready1, done1, err1, mem_rd1, mem_wr1;
  logic [31:0] rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        ready0, done0, err0, mem_rd0, mem_wr0;
  logic [31:0] rdata0, mem_addr0, mem_wdata0, mem_rdata0;

  logic [31:0] mem1 [0:63];
  logic [31:0] mem0 [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;

  int errors;
  int checks;

  lsu_subword #(.MISALIGN_TRAP(1'b1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .ready(ready1), .done(done1), .err(err1),
    .rdata(rdata1), .mem_rd(mem_rd1), .mem_wr(mem_wr1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  lsu_subword #(.MISALIGN_TRAP(1'b0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .ready(ready0), .done(done0), .err(err0),
    .rdata(rdata0), .mem_rd(mem_rd0), .mem_wr(mem_wr0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational memory read.
  assign mem_rdata1 = mem1[mem_addr1[7:2]];
  assign mem_rdata0 = mem0[mem_addr0[7:2]];

  // Memory write port.
  // Bench preload writes both memories; otherwise each DUT writes its own.
  always @(posedge clk) begin
    if (pl_en) begin
      mem1[pl_idx] <= pl_data;
      mem0[pl_idx] <= pl_data;
    end else begin
      if (mem_wr1) mem1[mem_addr1[7:2]] <= mem_wdata1;
      if (mem_wr0) mem0[mem_addr0[7:2]] <= mem_wdata0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    pl_en   = 1'b1;
    pl_idx  = idx;
    pl_data = data;
    tick();
    pl_en   = 1'b0;
  endtask

  // Presents one request for a single cycle to the selected DUTs.
  // On return the bench sits in cycle T+1.
  task automatic do_req(input logic s1, input logic s0, input logic w, input logic [1:0] sz,
                        input logic u, input logic [31:0] a, input logic [31:0] wd);
    we    = w;
    size  = sz;
    uns   = u;
    addr  = a;
    wdata = wd;
    req1  = s1;
    req0  = s0;
    tick();
    req1  = 1'b0;
    req0  = 1'b0;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset   = 1'b0;
    req1    = 1'b0;
    req0    = 1'b0;
    we      = 1'b0;
    size    = 2'b00;
    uns     = 1'b0;
    addr    = 32'h00000000;
    wdata   = 32'h00000000;
    pl_en   = 1'b0;
    pl_idx  = 6'd0;
    pl_data = 32'h00000000;

    // Reset state (memory preloaded while held in reset).
    preload(6'd4, 32'h80FF7F01);
    preload(6'd8, 32'hCAFEF00D);
    preload(6'd1, 32'h55555555);
    tick();
    check("rst_ready",     {31'd0, ready1},   32'd1);
    check("rst_done",      {31'd0, done1},    32'd0);
    check("rst_err",       {31'd0, err1},     32'd0);
    check("rst_rdata",     rdata1,            32'h00000000);
    check("rst_mem_rd",    {31'd0, mem_rd1},  32'd0);
    check("rst_mem_wr",    {31'd0, mem_wr1},  32'd0);
    check("rst_mem_addr",  mem_addr1,         32'h00000000);
    check("rst_mem_wdata", mem_wdata1,        32'h00000000);
    reset = 1'b1;
    tick();

    // lb 0x13, signed.
    do_req(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h00000013, 32'h0);
    check("lb_t1_mem_rd",   {31'd0, mem_rd1}, 32'd1);
    check("lb_t1_ready",    {31'd0, ready1},  32'd0);
    check("lb_t1_mem_addr", mem_addr1,        32'h00000010);
    check("lb_t1_done",     {31'd0, done1},   32'd0);
    tick();
    check("lb_t2_done",  {31'd0, done1}, 32'd1);
    check("lb_s_rdata",  rdata1,         32'hFFFFFF80);

    // lb 0x13, unsigned.
    tick();
    do_req(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 32'h00000013, 32'h0);
    tick();
    check("lbu_done",  {31'd0, done1}, 32'd1);
    check("lbu_rdata", rdata1,         32'h00000080);

    // lh 0x10 and 0x12 signed; lw 0x10.
    do_req(1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 32'h00000010, 32'h0);
    tick();
    check("lh10_rdata", rdata1, 32'h00007F01);
    do_req(1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 32'h00000012, 32'h0);
    tick();
    check("lh12_rdata", rdata1, 32'hFFFF80FF);
    do_req(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h00000010, 32'h0);
    tick();
    check("lw10_rdata", rdata1, 32'h80FF7F01);

    // sh 0x12 read-modify-write.
    preload(6'd4, 32'h11223344);
    do_req(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h00000012, 32'h0000BEEF);
    check("sh_t1_mem_rd", {31'd0, mem_rd1}, 32'd1);
    check("sh_t1_mem_wr", {31'd0, mem_wr1}, 32'd0);
    tick();
    check("sh_t2_mem_wr",    {31'd0, mem_wr1}, 32'd1);
    check("sh_t2_mem_rd",    {31'd0, mem_rd1}, 32'd0);
    check("sh_t2_mem_addr",  mem_addr1,        32'h00000010);
    check("sh_t2_mem_wdata", mem_wdata1,       32'hBEEF3344);
    check("sh_t2_done",      {31'd0, done1},   32'd0);
    tick();
    check("sh_t3_done",  {31'd0, done1}, 32'd1);
    check("sh_mem",      mem1[4],        32'hBEEF3344);
    check("sh_rdata_kept", rdata1,       32'h80FF7F01);

    // sb 0x11, upper wdata bits must be ignored.
    do_req(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h00000011, 32'h123456AA);
    tick();
    tick();
    check("sb_done", {31'd0, done1}, 32'd1);
    check("sb_mem",  mem1[4],        32'hBEEFAA44);

    // sw 0x06 misaligned: dut1 traps, dut0 aligns to 0x04.
    do_req(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h00000006, 32'hDEADBEEF);
    check("swm_err1",      {31'd0, err1},    32'd1);
    check("swm_done1",     {31'd0, done1},   32'd0);
    check("swm_ready1",    {31'd0, ready1},  32'd1);
    check("swm_mem_wr1",   {31'd0, mem_wr1}, 32'd0);
    check("swm_mem_wr0",   {31'd0, mem_wr0}, 32'd1);
    check("swm_mem_addr0", mem_addr0,        32'h00000004);
    check("swm_err0",      {31'd0, err0},    32'd0);
    tick();
    check("swm_t2_err1",    {31'd0, err1},    32'd0);
    check("swm_t2_mem_wr1", {31'd0, mem_wr1}, 32'd0);
    check("swm_t2_done0",   {31'd0, done0},   32'd1);
    check("swm_mem1",       mem1[1],          32'h55555555);
    check("swm_mem0",       mem0[1],          32'hDEADBEEF);

    // lh 0x11 on dut0 is realigned to 0x10.
    do_req(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h00000011, 32'h0);
    tick();
    check("lhm0_done",  {31'd0, done0}, 32'd1);
    check("lhm0_rdata", rdata0,         32'h00003344);

    // Reserved size rejected in both configurations.
    do_req(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h00000010, 32'h0);
    check("sz11_err1",    {31'd0, err1},    32'd1);
    check("sz11_err0",    {31'd0, err0},    32'd1);
    check("sz11_mem_rd1", {31'd0, mem_rd1}, 32'd0);
    check("sz11_mem_rd0", {31'd0, mem_rd0}, 32'd0);
    check("sz11_rdata1",  rdata1,           32'h80FF7F01);
    tick();

    // Reset while sb sits in RMW_RD.
    do_req(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h00000010, 32'h00000077);
    check("rstm_t1_mem_rd", {31'd0, mem_rd1}, 32'd1);
    reset = 1'b0;
    tick();
    check("rstm_mem_wr", {31'd0, mem_wr1}, 32'd0);
    check("rstm_ready",  {31'd0, ready1},  32'd1);
    check("rstm_done",   {31'd0, done1},   32'd0);
    reset = 1'b1;
    tick();
    check("rstm_done2", {31'd0, done1},   32'd0);
    check("rstm_mem",   mem1[4],          32'hBEEFAA44);

    // Back-to-back. First a load to give rdata a known value.
    do_req(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 32'h00000013, 32'h0);
    tick();
    check("b2b_lbu_rdata", rdata1, 32'h000000BE);

    // sb 0x10 with req held high.
    // While ready=0 the inputs switch to lw 0x20, which must be ignored.
    we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h00000010; wdata = 32'h00000099;
    req1 = 1'b1;
    tick();
    we = 1'b0; size = 2'b10; addr = 32'h00000020;
    check("b2b_t1_ready",    {31'd0, ready1},  32'd0);
    check("b2b_t1_mem_addr", mem_addr1,        32'h00000010);
    tick();
    check("b2b_t2_mem_wr",    {31'd0, mem_wr1}, 32'd1);
    check("b2b_t2_mem_addr",  mem_addr1,        32'h00000010);
    check("b2b_t2_mem_wdata", mem_wdata1,       32'hBEEFAA99);
    tick();
    check("b2b_t3_done",  {31'd0, done1},  32'd1);
    check("b2b_t3_ready", {31'd0, ready1}, 32'd1);
    check("b2b_t3_rdata", rdata1,          32'h000000BE);
    check("b2b_mem",      mem1[4],         32'hBEEFAA99);
    tick();
    req1 = 1'b0;
    check("b2b_lw_mem_rd",   {31'd0, mem_rd1}, 32'd1);
    check("b2b_lw_mem_addr", mem_addr1,        32'h00000020);
    check("b2b_lw_done",     {31'd0, done1},   32'd0);
    tick();
    check("b2b_lw_done2", {31'd0, done1}, 32'd1);
    check("b2b_lw_rdata", rdata1,         32'hCAFEF00D);

    // Store after the load: rdata must not change.
    do_req(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h00000020, 32'h00001234);
    tick();
    tick();
    check("sh20_done",  {31'd0, done1}, 32'd1);
    check("sh20_rdata", rdata1,         32'hCAFEF00D);
    check("sh20_mem",   mem1[8],        32'hCAFE1234);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
